// File: rtl/adder_64_result_buf_if.sv
// Result-buffer bus: adder issue/result side plus the output stream.
// The producer/consumer side is master, the buffer itself is slave.
interface adder_64_result_buf_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
);
   logic                     issue_valid;
   logic                     issue_ready;
   logic [WIDTH-1:0]         res_sum;
   logic                     res_carry;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_sum;
   logic                     out_carry;
   logic [$clog2(DEPTH):0]   fifo_count;

   modport master (
      output issue_valid,
      output res_sum,
      output res_carry,
      output out_ready,
      input  issue_ready,
      input  out_valid,
      input  out_sum,
      input  out_carry,
      input  fifo_count
   );

   modport slave (
      input  issue_valid,
      input  res_sum,
      input  res_carry,
      input  out_ready,
      output issue_ready,
      output out_valid,
      output out_sum,
      output out_carry,
      output fifo_count
   );
endinterface

// File: rtl/adder_64_result_buf.sv
// Result stage for a fixed-latency pipelined adder: tags issues,
// captures tagged results into a FIFO, credit-gates new issues.
module adder_64_result_buf #(
   parameter int WIDTH   = 64,
   parameter int LATENCY = 4,
   parameter int DEPTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_64_result_buf_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = $clog2(LATENCY + 1);
   localparam int SW = ((CW > IW) ? CW : IW) + 1;

   logic [LATENCY-1:0] vld_q, vld_d;
   logic [IW-1:0]      infl_q, infl_d;
   logic [PW-1:0]      wptr_q, wptr_d;
   logic [PW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     mem_q [DEPTH];

   logic [SW-1:0]      credit;
   logic               fire;
   logic               capture;
   logic               pop;
   logic               empty;

   // Credit uses registered occupancy only, so a same-cycle pop
   // cannot raise issue_ready until the following cycle.
   always_comb begin
      credit          = SW'(cnt_q) + SW'(infl_q);
      bus.issue_ready = !rst && (credit < SW'(DEPTH));
      fire            = bus.issue_valid & bus.issue_ready;
      capture         = vld_q[LATENCY-1];
      empty           = (cnt_q == '0);
      bus.out_valid   = !empty;
      pop             = !empty & bus.out_ready;
      bus.fifo_count  = cnt_q;
      {bus.out_carry, bus.out_sum} = empty ? '0 : mem_q[rptr_q];
   end

   // Next-state: tag shift, in-flight count, pointers and occupancy.
   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = fire;

      infl_d = infl_q;
      unique case (1'b1)
         (fire & !capture): infl_d = infl_q + IW'(1);
         (!fire & capture): infl_d = infl_q - IW'(1);
         default:           infl_d = infl_q;
      endcase

      wptr_d = capture ? wptr_q + PW'(1) : wptr_q;
      rptr_d = pop ? rptr_q + PW'(1) : rptr_q;

      cnt_d = cnt_q;
      unique case (1'b1)
         (capture & !pop): cnt_d = cnt_q + CW'(1);
         (!capture & pop): cnt_d = cnt_q - CW'(1);
         default:          cnt_d = cnt_q;
      endcase
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         infl_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         infl_q <= infl_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Result storage; contents are don't-care until counted valid.
   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         mem_q[wptr_q] <= {bus.res_carry, bus.res_sum};
      end
   end
endmodule
